// File: rtl/vita_rx_control_mc.sv
// vita_rx_control_mc: multi-channel RX timed-command controller.
// Queues timed stream commands from the settings bus, gates capture on
// vita_time, and streams flagged sample/error words to the VITA framer.
// Optional build macro: VITA_RX_OVERRUN_RESUME_EN. When it is defined, the
// controller resumes the active command after an overrun.
module vita_rx_control_mc #(
  parameter int BASE     = 0,
  parameter int WIDTH    = 32,
  parameter int NUM_CH   = 2,
  parameter int CMD_AW   = 4,
  parameter int SFIFO_AW = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clear,
  input  logic                           set_stb,
  input  logic [7:0]                     set_addr,
  input  logic [31:0]                    set_data,
  input  logic [63:0]                    vita_time,
  input  logic [NUM_CH*WIDTH-1:0]        sample,
  input  logic                           strobe,
  output logic                           run,
  output logic [5+64+NUM_CH*WIDTH-1:0]   sample_fifo_o,
  output logic                           sample_fifo_src_rdy_o,
  input  logic                           sample_fifo_dst_rdy_i,
  output logic                           overrun,
  output logic                           cmd_dropped,
  output logic [15:0]                    overrun_count,
  output logic [31:0]                    debug
);
  localparam int SW = NUM_CH * WIDTH;
  localparam int OW = 5 + 64 + SW;
  localparam logic [CMD_AW:0]   CMD_FULL = {1'b1, {CMD_AW{1'b0}}};
  localparam logic [SFIFO_AW:0] SF_FULL  = {1'b1, {SFIFO_AW{1'b0}}};
  localparam logic [7:0] ADDR_CMD  = 8'(BASE);
  localparam logic [7:0] ADDR_THI  = 8'(BASE + 1);
  localparam logic [7:0] ADDR_TLO  = 8'(BASE + 2);
  localparam logic [7:0] ADDR_MASK = 8'(BASE + 3);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_WAITING = 3'd1, S_RUNNING = 3'd2, S_OVERRUN = 3'd3,
    S_LATECMD = 3'd4, S_BROKENCHAIN = 3'd5, S_ZEROLEN = 3'd6
  } state_t;

  state_t state_q, state_d;
  logic [31:0] cmd_word_q, cmd_word_d, time_hi_q, time_hi_d;
  logic pend_q, pend_d;
  logic [95:0] pend_entry_q, pend_entry_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CMD_AW-1:0] cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
  logic [CMD_AW:0] cmd_cnt_q, cmd_cnt_d;
  logic dropped_q, dropped_d;
  logic [SFIFO_AW-1:0] sf_wp_q, sf_wp_d, sf_rp_q, sf_rp_d;
  logic [SFIFO_AW:0] sf_cnt_q, sf_cnt_d;
  logic [27:0] lines_left_q, lines_left_d, lines_total_q, lines_total_d;
  logic [63:0] time_q, time_d;
  logic send_imm_q, send_imm_d, chain_q, chain_d, reload_q, reload_d;
  logic settle_q, settle_d, now_q, now_d, late_q, late_d;
  logic [15:0] ovr_cnt_q, ovr_cnt_d;

  logic [95:0] cmd_mem [2**CMD_AW];
  logic [OW-1:0] sf_mem [2**SFIFO_AW];

  logic cmd_pop, cmd_wr_en, sf_wr_en, sf_rd, cmd_full, cmd_empty, sf_full, sf_empty, cmd_done;
  logic [OW-1:0] sf_wdata;
  logic [SW-1:0] masked;
  logic [31:0] head_cmd;
  logic [63:0] head_time;

  assign head_cmd  = cmd_mem[cmd_rp_q][95:64];
  assign head_time = cmd_mem[cmd_rp_q][63:0];
  assign cmd_full  = (cmd_cnt_q == CMD_FULL);
  assign cmd_empty = (cmd_cnt_q == '0);
  assign sf_full   = (sf_cnt_q == SF_FULL);
  assign sf_empty  = (sf_cnt_q == '0);
  assign cmd_done  = (lines_left_q == 28'd1) & (~chain_q | (~cmd_empty & head_cmd[28]));

  // Disabled lanes are forced to zero before they reach the sample FIFO.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
    assign masked[gi*WIDTH +: WIDTH] = mask_q[gi] ? sample[gi*WIDTH +: WIDTH] : '0;
  end

  assign run                   = (state_q == S_RUNNING);
  assign overrun               = (state_q == S_OVERRUN);
  assign cmd_dropped           = dropped_q;
  assign overrun_count         = ovr_cnt_q;
  assign sample_fifo_src_rdy_o = ~sf_empty;
  assign sample_fifo_o         = sf_empty ? '0 : sf_mem[sf_rp_q];
  assign debug                 = {state_q, 5'(cmd_cnt_q), 24'h0};

  // Settings decode, command/sample queue bookkeeping and the control FSM.
  always_comb begin
    state_d = state_q;  cmd_word_d = cmd_word_q;  time_hi_d = time_hi_q;
    pend_d = 1'b0;  pend_entry_d = pend_entry_q;  mask_d = mask_q;
    cmd_wp_d = cmd_wp_q;  cmd_rp_d = cmd_rp_q;  cmd_cnt_d = cmd_cnt_q;  dropped_d = dropped_q;
    sf_wp_d = sf_wp_q;  sf_rp_d = sf_rp_q;  sf_cnt_d = sf_cnt_q;
    lines_left_d = lines_left_q;  lines_total_d = lines_total_q;  time_d = time_q;
    send_imm_d = send_imm_q;  chain_d = chain_q;  reload_d = reload_q;
    settle_d = settle_q;  ovr_cnt_d = ovr_cnt_q;
    now_d  = (vita_time == time_q);
    late_d = (vita_time > time_q);
    cmd_pop = 1'b0;  sf_wr_en = 1'b0;  sf_wdata = '0;

    if (set_stb) begin
      if (set_addr == ADDR_CMD) cmd_word_d = set_data;
      if (set_addr == ADDR_THI) time_hi_d = set_data;
      if (set_addr == ADDR_TLO) begin
        pend_d       = 1'b1;
        pend_entry_d = {cmd_word_q, time_hi_q, set_data};
      end
      if (set_addr == ADDR_MASK) mask_d = set_data[NUM_CH-1:0];
    end

    case (state_q)
      S_IDLE: if (!cmd_empty) begin
        cmd_pop = 1'b1;
        lines_left_d = head_cmd[27:0];  lines_total_d = head_cmd[27:0];  time_d = head_time;
        send_imm_d = head_cmd[31];  chain_d = head_cmd[30];  reload_d = head_cmd[29];
        settle_d = 1'b1;
        state_d = (head_cmd[28] || head_cmd[27:0] == 28'd0) ? S_ZEROLEN : S_WAITING;
      end
      S_WAITING: begin
        // The comparator is one cycle behind a freshly loaded time, so skip a cycle.
        if (settle_q) settle_d = 1'b0;
        else if (now_q || send_imm_q) state_d = S_RUNNING;
        else if (late_q) state_d = S_LATECMD;
      end
      S_RUNNING: if (strobe) begin
        if (sf_full) begin
          state_d = S_OVERRUN;
          if (ovr_cnt_q != 16'hFFFF) ovr_cnt_d = ovr_cnt_q + 16'd1;
        end else begin
          sf_wr_en = 1'b1;
          sf_wdata = {4'b0000, cmd_done, vita_time, masked};
          if (lines_left_q != 28'd1) lines_left_d = lines_left_q - 28'd1;
          else if (!chain_q) state_d = S_IDLE;
          else if (cmd_empty) begin
            if (reload_q) lines_left_d = lines_total_q;
            else state_d = S_BROKENCHAIN;
          end else begin
            // Chained follow-up starts immediately, without a time check.
            cmd_pop = 1'b1;
            if (head_cmd[28]) state_d = S_IDLE;
            else if (head_cmd[27:0] == 28'd0) state_d = S_ZEROLEN;
            else begin
              lines_left_d = head_cmd[27:0];  lines_total_d = head_cmd[27:0];  time_d = head_time;
              send_imm_d = head_cmd[31];  chain_d = head_cmd[30];  reload_d = head_cmd[29];
            end
          end
        end
      end
      S_OVERRUN, S_LATECMD, S_BROKENCHAIN, S_ZEROLEN: if (!sf_full) begin
        sf_wr_en = 1'b1;
        case (state_q)
          S_OVERRUN:     sf_wdata = {5'b01000, vita_time, {SW{1'b0}}};
          S_LATECMD:     sf_wdata = {5'b00010, vita_time, {SW{1'b0}}};
          S_BROKENCHAIN: sf_wdata = {5'b00100, vita_time, {SW{1'b0}}};
          default:       sf_wdata = {5'b10000, vita_time, {SW{1'b0}}};
        endcase
`ifdef VITA_RX_OVERRUN_RESUME_EN
        state_d = (state_q == S_OVERRUN) ? S_RUNNING : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // A push into a full queue only succeeds when the head leaves in the same cycle.
    cmd_wr_en = pend_q && (!cmd_full || cmd_pop);
    if (pend_q && cmd_full && !cmd_pop) dropped_d = 1'b1;
    if (cmd_wr_en) cmd_wp_d = cmd_wp_q + 1'b1;
    if (cmd_pop) cmd_rp_d = cmd_rp_q + 1'b1;
    if (cmd_wr_en && !cmd_pop) cmd_cnt_d = cmd_cnt_q + 1'b1;
    else if (!cmd_wr_en && cmd_pop) cmd_cnt_d = cmd_cnt_q - 1'b1;

    sf_rd = !sf_empty && sample_fifo_dst_rdy_i;
    if (sf_wr_en) sf_wp_d = sf_wp_q + 1'b1;
    if (sf_rd) sf_rp_d = sf_rp_q + 1'b1;
    if (sf_wr_en && !sf_rd) sf_cnt_d = sf_cnt_q + 1'b1;
    else if (!sf_wr_en && sf_rd) sf_cnt_d = sf_cnt_q - 1'b1;

    if (clear) begin
      state_d = S_IDLE;  cmd_word_d = '0;  time_hi_d = '0;  pend_d = 1'b0;  pend_entry_d = '0;
      cmd_wp_d = '0;  cmd_rp_d = '0;  cmd_cnt_d = '0;  dropped_d = 1'b0;
      sf_wp_d = '0;  sf_rp_d = '0;  sf_cnt_d = '0;
      lines_left_d = '0;  lines_total_d = '0;  time_d = '0;
      send_imm_d = 1'b0;  chain_d = 1'b0;  reload_d = 1'b0;
      settle_d = 1'b0;  now_d = 1'b0;  late_d = 1'b0;  ovr_cnt_d = '0;
      cmd_wr_en = 1'b0;  sf_wr_en = 1'b0;
    end
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;  cmd_word_q <= '0;  time_hi_q <= '0;  pend_q <= 1'b0;  pend_entry_q <= '0;
      mask_q <= '1;  cmd_wp_q <= '0;  cmd_rp_q <= '0;  cmd_cnt_q <= '0;  dropped_q <= 1'b0;
      sf_wp_q <= '0;  sf_rp_q <= '0;  sf_cnt_q <= '0;
      lines_left_q <= '0;  lines_total_q <= '0;  time_q <= '0;
      send_imm_q <= 1'b0;  chain_q <= 1'b0;  reload_q <= 1'b0;
      settle_q <= 1'b0;  now_q <= 1'b0;  late_q <= 1'b0;  ovr_cnt_q <= '0;
    end else begin
      state_q <= state_d;  cmd_word_q <= cmd_word_d;  time_hi_q <= time_hi_d;
      pend_q <= pend_d;  pend_entry_q <= pend_entry_d;
      mask_q <= mask_d;  cmd_wp_q <= cmd_wp_d;  cmd_rp_q <= cmd_rp_d;  cmd_cnt_q <= cmd_cnt_d;
      dropped_q <= dropped_d;  sf_wp_q <= sf_wp_d;  sf_rp_q <= sf_rp_d;  sf_cnt_q <= sf_cnt_d;
      lines_left_q <= lines_left_d;  lines_total_q <= lines_total_d;  time_q <= time_d;
      send_imm_q <= send_imm_d;  chain_q <= chain_d;  reload_q <= reload_d;
      settle_q <= settle_d;  now_q <= now_d;  late_q <= late_d;  ovr_cnt_q <= ovr_cnt_d;
    end
  end

  // Queue storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (cmd_wr_en) cmd_mem[cmd_wp_q] <= pend_entry_q;
    if (sf_wr_en) sf_mem[sf_wp_q] <= sf_wdata;
  end
endmodule

// File: tb/tb_vita_rx_control_mc.sv
// Directed bench for vita_rx_control_mc, built with four lanes.
module tb_vita_rx_control_mc;
  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int OW  = 5 + 64 + NCH * W;
  localparam logic [7:0] BASE = 8'h10;
  localparam logic [127:0] SAMP = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

  logic clk = 1'b0;
  logic reset_n, clear, set_stb, strobe, run, src_rdy, dst_rdy, overrun, cmd_dropped;
  logic [7:0] set_addr;
  logic [31:0] set_data, debug;
  logic [63:0] vita_time;
  logic [NCH*W-1:0] sample;
  logic [OW-1:0] fifo_o;
  logic [15:0] overrun_count;

  int n_vec = 0;
  int n_err = 0;
  logic [OW-1:0] cap_q [$];

  always #5 clk = ~clk;

  vita_rx_control_mc #(.BASE(16), .WIDTH(W), .NUM_CH(NCH), .CMD_AW(4), .SFIFO_AW(4)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .vita_time(vita_time), .sample(sample), .strobe(strobe), .run(run),
    .sample_fifo_o(fifo_o), .sample_fifo_src_rdy_o(src_rdy), .sample_fifo_dst_rdy_i(dst_rdy),
    .overrun(overrun), .cmd_dropped(cmd_dropped), .overrun_count(overrun_count), .debug(debug)
  );

  // Record every word the framer accepts; inputs are stable from negedge to posedge.
  always @(negedge clk) begin
    if (src_rdy && dst_rdy) begin
      cap_q.push_back(fifo_o);
      $display("xfer %0d flags=%05b time=%0d data=%h", cap_q.size() - 1,
               fifo_o[OW-1 -: 5], fifo_o[191:128], fifo_o[127:0]);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] w_flags(input int i);
    if (i >= cap_q.size()) return '1;
    return 64'(cap_q[i][OW-1 -: 5]);
  endfunction

  function automatic logic [63:0] w_time(input int i);
    if (i >= cap_q.size()) return '1;
    return cap_q[i][191:128];
  endfunction

  function automatic logic [63:0] w_hi(input int i);
    if (i >= cap_q.size()) return '1;
    return cap_q[i][127:64];
  endfunction

  function automatic logic [63:0] w_lo(input int i);
    if (i >= cap_q.size()) return '1;
    return cap_q[i][63:0];
  endfunction

  function automatic logic [31:0] mk(input bit si, input bit ch, input bit rl, input bit st,
                                     input logic [27:0] n);
    return {si, ch, rl, st, n};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic push_cmd(input logic [31:0] c, input logic [63:0] t);
    set_wr(BASE, c);
    set_wr(BASE + 8'd1, t[63:32]);
    set_wr(BASE + 8'd2, t[31:0]);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    strobe = 1'b0; dst_rdy = 1'b1; vita_time = '0; sample = SAMP;
    idle(2);
    check("rst_run", 64'(run), 64'd0);
    check("rst_src_rdy", 64'(src_rdy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_dropped", 64'(cmd_dropped), 64'd0);
    check("rst_ovr_cnt", 64'(overrun_count), 64'd0);
    check("rst_debug", 64'(debug), 64'd0);
    check("rst_fifo_o", fifo_o[63:0], 64'd0);
    reset_n = 1'b1;
    idle(2);

    // Immediate command, four lines.
    cap_q.delete(); vita_time = 64'd5; strobe = 1'b1;
    push_cmd(mk(1, 0, 0, 0, 28'd4), 64'd0);
    idle(20); strobe = 1'b0;
    check("imm_count", 64'(cap_q.size()), 64'd4);
    check("imm_flags0", w_flags(0), 64'd0);
    check("imm_flags2", w_flags(2), 64'd0);
    check("imm_flags3", w_flags(3), 64'd1);
    check("imm_time0", w_time(0), 64'd5);
    check("imm_hi0", w_hi(0), SAMP[127:64]);
    check("imm_lo0", w_lo(0), SAMP[63:0]);
    check("imm_state", 64'(debug[31:29]), 64'd0);

    // Timed command at 1000.
    cap_q.delete(); vita_time = 64'd900; strobe = 1'b1;
    push_cmd(mk(0, 0, 0, 0, 28'd2), 64'd1000);
    idle(10);
    check("timed_early_count", 64'(cap_q.size()), 64'd0);
    check("timed_waiting", 64'(debug[31:29]), 64'd1);
    vita_time = 64'd1000;
    idle(10); strobe = 1'b0;
    check("timed_count", 64'(cap_q.size()), 64'd2);
    check("timed_time0", w_time(0), 64'd1000);
    check("timed_flags0", w_flags(0), 64'd0);
    check("timed_flags1", w_flags(1), 64'd1);
    check("timed_state", 64'(debug[31:29]), 64'd0);

    // Late command.
    cap_q.delete(); vita_time = 64'd600; strobe = 1'b1;
    push_cmd(mk(0, 0, 0, 0, 28'd3), 64'd500);
    idle(10); strobe = 1'b0;
    check("late_count", 64'(cap_q.size()), 64'd1);
    check("late_flags", w_flags(0), 64'h02);
    check("late_state", 64'(debug[31:29]), 64'd0);

    // Chain with no follow-up and no reload.
    cap_q.delete(); vita_time = 64'd700; strobe = 1'b1;
    push_cmd(mk(1, 1, 0, 0, 28'd3), 64'd0);
    idle(15); strobe = 1'b0;
    check("chain_count", 64'(cap_q.size()), 64'd4);
    check("chain_flags0", w_flags(0), 64'd0);
    check("chain_flags2", w_flags(2), 64'd0);
    check("chain_flags3", w_flags(3), 64'h04);
    check("chain_state", 64'(debug[31:29]), 64'd0);

    // Lane mask 0101, kept across a clear.
    set_wr(BASE + 8'd3, 32'h5);
    clear_pulse();
    cap_q.delete(); strobe = 1'b1;
    push_cmd(mk(1, 0, 0, 0, 28'd2), 64'd0);
    idle(12); strobe = 1'b0;
    check("mask_count", 64'(cap_q.size()), 64'd2);
    check("mask_hi0", w_hi(0), 64'h00000000_CCCC0002);
    check("mask_lo0", w_lo(0), 64'h00000000_AAAA0000);
    check("mask_hi1", w_hi(1), 64'h00000000_CCCC0002);
    check("mask_lo1", w_lo(1), 64'h00000000_AAAA0000);
    check("mask_flags1", w_flags(1), 64'd1);
    set_wr(BASE + 8'd3, 32'hF);

    // Overrun with the framer stalled.
    cap_q.delete(); dst_rdy = 1'b0; strobe = 1'b1;
    push_cmd(mk(1, 0, 0, 0, 28'd100), 64'd0);
    idle(30);
    check("ovr_flag", 64'(overrun), 64'd1);
    check("ovr_cnt", 64'(overrun_count), 64'd1);
    check("ovr_state", 64'(debug[31:29]), 64'd3);
    check("ovr_src_rdy", 64'(src_rdy), 64'd1);
    strobe = 1'b0; dst_rdy = 1'b1;
    idle(25);
    check("ovr_count", 64'(cap_q.size()), 64'd17);
    check("ovr_flags0", w_flags(0), 64'd0);
    check("ovr_flags15", w_flags(15), 64'd0);
    check("ovr_flags16", w_flags(16), 64'h08);
    check("ovr_cnt_after", 64'(overrun_count), 64'd1);
`ifdef VITA_RX_OVERRUN_RESUME_EN
    check("ovr_resume_state", 64'(debug[31:29]), 64'd2);
    clear_pulse();
`else
    check("ovr_end_state", 64'(debug[31:29]), 64'd0);
`endif

    // Queue overflow while waiting on a far-future command.
    vita_time = 64'd0;
    push_cmd(mk(0, 0, 0, 0, 28'd1), 64'd1000000);
    idle(2);
    check("drop_waiting", 64'(debug[31:29]), 64'd1);
    check("drop_before", 64'(cmd_dropped), 64'd0);
    for (int i = 0; i < 17; i++) push_cmd(mk(1, 0, 0, 0, 28'(i + 1)), 64'd1000000);
    idle(2);
    check("drop_flag", 64'(cmd_dropped), 64'd1);
    check("drop_occupancy", 64'(debug[28:24]), 64'd16);
    check("drop_state", 64'(debug[31:29]), 64'd1);
    clear_pulse();
    check("clr_dropped", 64'(cmd_dropped), 64'd0);
    check("clr_occupancy", 64'(debug[28:24]), 64'd0);
    check("clr_state", 64'(debug[31:29]), 64'd0);
    check("clr_ovr_cnt", 64'(overrun_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vita_rx_control_mc.md
Name: vita_rx_control_mc

Overview:
Multi-channel, parametrised successor of the single-channel RX timed-command controller. Sits between the DSP cores (NUM_CH lanes sharing one strobe) and the VITA RX framer.
- Queues timed stream commands from the settings bus.
- Gates sample capture against vita_time.
- Emits flagged sample/error words.
- Adds configurable queue depths, a per-channel enable mask, a dropped-command flag, and an overrun counter.

Parameters:
BASE, 0, settings-bus base address (uses BASE..BASE+3)
WIDTH, 32, bits per channel sample
NUM_CH, 2, channel count (1..8)
CMD_AW, 4, log2 of command queue depth (16 entries)
SFIFO_AW, 4, log2 of sample FIFO depth (16 entries)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear; same effect as reset except the enable mask is kept
set_stb  in  1  settings strobe
set_addr  in  8  settings address
set_data  in  32  settings data
vita_time  in  64  current time
sample  in  NUM_CH*WIDTH  lane 0 in LSBs
strobe  in  1  sample valid from DSP
run  out  1  capture active
sample_fifo_o  out  5+64+NUM_CH*WIDTH  {flags[4:0], vita_time, samples}
sample_fifo_src_rdy_o  out  1  output word valid
sample_fifo_dst_rdy_i  in  1  framer ready
overrun  out  1  high in OVERRUN state
cmd_dropped  out  1  sticky; a command arrived while the queue was full
overrun_count  out  16  saturating overrun count
debug  out  32  {state[2:0], queue occupancy[4:0], 24'h0}

Behaviour:
- Reset (reset_n low, async): state IDLE; all outputs 0; both FIFOs empty; enable mask all-ones. Clear does the same synchronously, except the mask is kept.
- Settings registers:
  - BASE: command word {send_imm[31], chain[30], reload[29], stop[28], numlines[27:0]}.
  - BASE+1: time_hi.
  - BASE+2: time_lo. A write here pushes {cmd, time} into the command queue 1 cycle after the strobe.
  - BASE+3: enable mask [NUM_CH-1:0]. A disabled lane's sample bits are written as zero.
- Push when the queue is full: command discarded, cmd_dropped set (cleared only by reset/clear). A push and a pop in the same cycle on a full queue are both accepted.
- Flags: {zerolen, overrun, brokenchain, latecmd, cmd_done}.
  - cmd_done = (lines_left==1) & (~chain | (queue not empty & head.stop)).
- late/now comparison is registered: 1 cycle of latency.
- State machine:
  - IDLE: queue not empty -> pop, load lines_left/lines_total/time/modes. Go to ZEROLEN if stop or numlines==0, else WAITING.
  - WAITING: first cycle is a settle cycle. Afterwards: (now | send_imm) -> RUNNING; registered (late & ~send_imm) -> LATECMD.
  - RUNNING: run=1. On strobe:
    - sample FIFO full -> OVERRUN; the sample is not written and overrun_count increments, saturating at 16'hFFFF.
    - otherwise write {flags, vita_time, samples} and decrement lines_left.
  - RUNNING at lines_left==1 (on a written strobe):
    - ~chain -> IDLE.
    - chain & empty queue & reload -> reload lines_total, stay RUNNING.
    - chain & empty queue & ~reload -> BROKENCHAIN.
    - chain & queue not empty -> pop the head without a time check; head.stop -> IDLE, else stay RUNNING.
  - OVERRUN/LATECMD/BROKENCHAIN/ZEROLEN: attempt one flag-only word each cycle until the sample FIFO accepts it, then -> IDLE.
- Output side uses ready/valid: a word transfers when src_rdy & dst_rdy. Output order equals write order; no word is ever duplicated or dropped once accepted.
- numlines is 28-bit unsigned; lines_left never wraps below 1 while in RUNNING.

Optional Feature:
VITA_RX_OVERRUN_RESUME_EN
- Defined: after the OVERRUN flag word is accepted, return to RUNNING with lines_left, chain and reload unchanged. The stream continues without the host reissuing the command; the skipped samples are lost.
- Undefined: OVERRUN -> IDLE. The remaining lines of the active command are abandoned.

Test Plan:
- send_imm, numlines=4, dst_rdy=1, strobe every cycle -> 4 words; cmd_done set only on the 4th; state returns to IDLE.
- Time command at T=1000, vita_time=900, numlines=2 -> no words before 1000; first word carries vita_time=1000.
- Command time 500 while vita_time=600, no send_imm -> exactly one word with flags=5'b00010; IDLE afterwards.
- numlines=3, chain=1, no follow-up command, reload=0 -> 3 data words, then one flag word 5'b00100.
- dst_rdy=0, continuous strobe, 16-entry FIFO:
  - without the macro: 16 data words, then overrun flag 5'b01000, overrun_count=1, IDLE.
  - with the macro: after the flag word, stream resumes with lines_left preserved.
- 17 commands pushed with no strobe and the controller in WAITING -> cmd_dropped=1; the 17th command is never executed.
- NUM_CH=4, mask=4'b0101 -> lanes 1 and 3 read zero in every word.
